// File: rtl/p_mult_lanes.sv
// Multi-lane pipelined multiplier with one shared valid/ready handshake and a signed/unsigned mode per beat.
// Each lane also has a signed accumulator that lives in the output stage, so back-to-back MAC beats need no forwarding.
module p_mult_lanes #(
  parameter int WIDTH        = 8,
  parameter int LANES        = 4,
  parameter int MULT_LATENCY = 3,
  parameter int ACC_GUARD    = 8,
  localparam int ACC_W       = 2*WIDTH + ACC_GUARD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic [LANES*WIDTH-1:0]   dataa,
  input  logic [LANES*WIDTH-1:0]   datab,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ACC_W-1:0]   res
);

  localparam int PW = 2*WIDTH;

  localparam logic [1:0] MODE_UMUL = 2'b00;
  localparam logic [1:0] MODE_MAC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic                   adv;
  logic                   out_valid_reg;

  logic                   in_v_reg;
  logic [1:0]             in_mode_reg;
  logic [LANES*WIDTH-1:0] a_reg;
  logic [LANES*WIDTH-1:0] b_reg;

  logic [MULT_LATENCY-1:0] p_v_reg;
  logic [1:0]              p_mode_reg [MULT_LATENCY];

  logic       last_v;
  logic [1:0] last_mode;
  logic       op_signed;

  // The whole pipe moves as one; bubbles are kept rather than squeezed out.
  assign adv       = !out_valid_reg || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;

  assign last_v    = p_v_reg[MULT_LATENCY-1];
  assign last_mode = p_mode_reg[MULT_LATENCY-1];
  assign op_signed = (in_mode_reg != MODE_UMUL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_v_reg    <= 1'b0;
      in_mode_reg <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
    end else if (adv) begin
      in_v_reg    <= in_valid;
      in_mode_reg <= mode;
      a_reg       <= dataa;
      b_reg       <= datab;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_v_reg <= '0;
      for (int s = 0; s < MULT_LATENCY; s++) begin
        p_mode_reg[s] <= '0;
      end
    end else if (adv) begin
      p_v_reg[0]    <= in_v_reg;
      p_mode_reg[0] <= in_mode_reg;
      for (int s = 1; s < MULT_LATENCY; s++) begin
        p_v_reg[s]    <= p_v_reg[s-1];
        p_mode_reg[s] <= p_mode_reg[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
    end else if (adv) begin
      out_valid_reg <= last_v;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0]        a_op;
      logic [WIDTH-1:0]        b_op;
      logic [PW-1:0]           a_ext;
      logic [PW-1:0]           b_ext;
      logic [PW-1:0]           prod;
      logic [PW-1:0]           p_reg [MULT_LATENCY];
      logic [PW-1:0]           p_last;
      logic signed [PW-1:0]    p_last_s;
      logic signed [ACC_W-1:0] ext_s;
      logic [ACC_W-1:0]        ext_z;
      logic [ACC_W-1:0]        ext;
      logic [ACC_W-1:0]        acc_sum;
      logic [ACC_W-1:0]        acc_reg;
      logic [ACC_W-1:0]        res_reg;

      assign a_op = a_reg[gi*WIDTH +: WIDTH];
      assign b_op = b_reg[gi*WIDTH +: WIDTH];

      // Extending both operands to PW bits makes one PW-bit multiply correct for either signedness.
      assign a_ext = {{WIDTH{op_signed & a_op[WIDTH-1]}}, a_op};
      assign b_ext = {{WIDTH{op_signed & b_op[WIDTH-1]}}, b_op};
      assign prod  = a_ext * b_ext;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < MULT_LATENCY; s++) begin
            p_reg[s] <= '0;
          end
        end else if (adv) begin
          p_reg[0] <= prod;
          for (int s = 1; s < MULT_LATENCY; s++) begin
            p_reg[s] <= p_reg[s-1];
          end
        end
      end

      assign p_last   = p_reg[MULT_LATENCY-1];
      assign p_last_s = p_last;
      assign ext_s    = p_last_s;
      assign ext_z    = ACC_W'(p_last);
      assign ext      = (last_mode == MODE_UMUL) ? ext_z : ext_s;
      assign acc_sum  = acc_reg + ext;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          acc_reg <= '0;
          res_reg <= '0;
        end else if (adv && last_v) begin
          case (last_mode)
            MODE_MAC: begin
              acc_reg <= acc_sum;
              res_reg <= acc_sum;
            end
            MODE_LOAD: begin
              acc_reg <= ext;
              res_reg <= ext;
            end
            default: res_reg <= ext;
          endcase
        end
      end

      assign res[gi*ACC_W +: ACC_W] = res_reg;
    end
  endgenerate

endmodule

// File: tb/tb_p_mult_lanes.sv
// Bench for p_mult_lanes: directed steps plus random beats, scored against an arithmetic model of each beat.
module tb_p_mult_lanes;
  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int ML    = 3;
  localparam int AG    = 8;
  localparam int ACC_W = 2*WIDTH + AG;
  localparam int DW    = LANES*WIDTH;
  localparam int RW    = LANES*ACC_W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] dataa = '0;
  logic [DW-1:0] datab = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] res;

  p_mult_lanes #(
    .WIDTH(WIDTH), .LANES(LANES), .MULT_LATENCY(ML), .ACC_GUARD(AG)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .dataa(dataa), .datab(datab),
    .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_beat = 0;
  logic [RW-1:0] exp_q [$];
  longint acc_m [LANES];
  logic [RW-1:0] prev_res = '0;
  logic prev_stall = 1'b0;
  bit stop_bp = 1'b0;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result of one beat, straight from the mode rules: multiply as integers, keep ACC_W bits.
  function automatic logic [RW-1:0] model(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [RW-1:0] r;
    logic [7:0] x, y;
    longint pa, pb, p, v;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      x = a[l*WIDTH +: WIDTH];
      y = b[l*WIDTH +: WIDTH];
      if (m == 2'b00) begin
        pa = longint'(x);
        pb = longint'(y);
      end else begin
        pa = longint'($signed(x));
        pb = longint'($signed(y));
      end
      p = pa * pb;
      if (m == 2'b10) begin
        acc_m[l] = (acc_m[l] + p) & 64'hFF_FFFF;
        v = acc_m[l];
      end else if (m == 2'b11) begin
        acc_m[l] = p & 64'hFF_FFFF;
        v = acc_m[l];
      end else begin
        v = p & 64'hFF_FFFF;
      end
      r[l*ACC_W +: ACC_W] = v[ACC_W-1:0];
    end
    return r;
  endfunction

  // Scoreboard and handshake checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      check("in_ready_rule", RW'(in_ready), RW'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("stall_valid_hold", RW'(out_valid), RW'(1'b1));
        check("stall_res_hold", res, prev_res);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL extra_beat: observed %h expected no beat", res);
        end else begin
          logic [RW-1:0] e;
          e = exp_q.pop_front();
          n_beat++;
          $display("beat %0d res=%h expected=%h", n_beat, res, e);
          check("beat_res", res, e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = res;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Called and returns at one time unit after a rising edge.
  task automatic send(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit done;
    int guard;
    done = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    mode = m;
    dataa = a;
    datab = b;
    while (!done && guard < 500) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        exp_q.push_back(model(m, a, b));
      end
      @(posedge clk);
      #1;
      guard++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout: observed no acceptance expected acceptance");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain_empty", RW'(exp_q.size()), RW'(0));
  endtask

  initial begin
    int lat;
    logic [DW-1:0] ra, rb;
    for (int l = 0; l < LANES; l++) acc_m[l] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", RW'(in_ready), RW'(1'b1));
    check("reset_out_valid", RW'(out_valid), RW'(1'b0));
    check("reset_res", res, '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned products and latency.
    send(2'b00, {8'd3, 8'd255}, {8'd4, 8'd255});
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", RW'(lat), RW'(4));
    drain();
    check("umul_res", res, {24'h00000C, 24'h00FE01});

    // Same operands, signed then unsigned, back to back.
    send(2'b01, {8'd0, 8'hFF}, {8'd0, 8'h02});
    send(2'b00, {8'd0, 8'hFF}, {8'd0, 8'h02});
    drain();
    check("unsigned_after_signed", RW'(res[23:0]), RW'(24'h0001FE));

    // MAC sequence with a plain multiply in the middle.
    send(2'b11, {8'd0, 8'd10}, {8'd0, 8'd10});
    send(2'b10, {8'd0, 8'd5}, {8'd0, 8'hFD});
    drain();
    check("mac_85", RW'(res[23:0]), RW'(24'd85));
    send(2'b00, {8'd0, 8'd7}, {8'd0, 8'd7});
    drain();
    check("mul_between_mac", RW'(res[23:0]), RW'(24'd49));
    send(2'b10, {8'd0, 8'd1}, {8'd0, 8'd1});
    drain();
    check("mac_86", RW'(res[23:0]), RW'(24'd86));

    // Backpressure mid-stream.
    fork
      begin
        for (int i = 0; i < 6; i++) send(2'b01, {8'(i+1), 8'(i+10)}, {8'(2*i), 8'hF0});
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Accumulator wrap.
    send(2'b11, {8'd0, 8'h80}, {8'd0, 8'h80});
    for (int i = 0; i < 511; i++) send(2'b10, {8'd0, 8'h80}, {8'd0, 8'h80});
    drain();
    check("wrap_800000", RW'(res[23:0]), RW'(24'h800000));

    // Reset with beats in flight.
    send(2'b11, {8'd0, 8'd10}, {8'd0, 8'd10});
    send(2'b10, {8'd0, 8'd5}, {8'd0, 8'hFD});
    drain();
    check("pre_reset_85", RW'(res[23:0]), RW'(24'd85));
    send(2'b01, {8'd1, 8'd2}, {8'd3, 8'd4});
    send(2'b10, {8'd5, 8'd6}, {8'd7, 8'd8});
    send(2'b00, {8'd9, 8'd10}, {8'd11, 8'd12});
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_out_valid", RW'(out_valid), RW'(1'b0));
    check("async_reset_res", res, '0);
    check("async_reset_in_ready", RW'(in_ready), RW'(1'b1));
    exp_q.delete();
    for (int l = 0; l < LANES; l++) acc_m[l] = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(2'b10, {8'd0, 8'd2}, {8'd0, 8'd3});
    drain();
    check("mac_after_reset", RW'(res[23:0]), RW'(24'd6));

    // Random beats under random backpressure.
    stop_bp = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          ra = DW'($urandom);
          rb = DW'($urandom);
          send(2'($urandom_range(0, 3)), ra, rb);
        end
        stop_bp = 1'b1;
      end
      begin
        while (!stop_bp) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
